// File: rtl/priv_1_12_trap_sequencer_pkg.sv
// Shared machine-mode types for the v1.12 trap sequencer: FSM states, trap kind, mtvec/mcause layouts.
// Pure declarations; no latency or flow control of its own.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_seq_state_t;

  typedef enum logic {
    TRAP = 1'b0,
    RET  = 1'b1
  } trap_kind_t;

  localparam logic [1:0] DIRECT   = 2'd0;
  localparam logic [1:0] VECTORED = 2'd1;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        interrupt;
    logic [30:0] cause;
  } mcause_t;

endpackage

// File: rtl/priv_1_12_trap_sequencer_if.sv
// Bundle between the trap sequencer and int_ex_handler / CSR file / hazard unit.
// master = sequencer side, slave = environment side; level requests, strobe responses, no backpressure.
interface priv_1_12_trap_sequencer_if;
  import machine_mode_types_1_12_pkg::*;

  logic        trap_req;
  logic        mret;
  logic        pipe_clear;
  mtvec_t      curr_mtvec;
  mcause_t     curr_mcause;
  logic [31:0] curr_mepc;

  logic        pipe_stall;
  logic        pipe_flush;
  logic        trap_commit;
  logic        mret_commit;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        busy;
  logic        drain_timeout;

  modport master (
    input  trap_req, mret, pipe_clear, curr_mtvec, curr_mcause, curr_mepc,
    output pipe_stall, pipe_flush, trap_commit, mret_commit, insert_pc, priv_pc, busy, drain_timeout
  );

  modport slave (
    output trap_req, mret, pipe_clear, curr_mtvec, curr_mcause, curr_mepc,
    input  pipe_stall, pipe_flush, trap_commit, mret_commit, insert_pc, priv_pc, busy, drain_timeout
  );

endinterface

// File: rtl/priv_1_12_trap_vector_calc.sv
// Redirect target: vectored/direct mtvec for traps, aligned mepc for MRET.
// Purely combinational, zero latency, no flow control.
module priv_1_12_trap_vector_calc
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int VECTOR_CAUSES = 16
) (
  input  mtvec_t      i_mtvec,
  input  mcause_t     i_mcause,
  input  logic [31:0] i_mepc,
  input  trap_kind_t  i_kind,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic [31:0] w_mepc_aligned;
  logic [31:0] w_offset;
  logic        w_vectored;

  assign w_base         = {i_mtvec.base, 2'b00};
  assign w_mepc_aligned = i_mepc & ~32'h3;
  assign w_offset       = {i_mcause.cause[29:0], 2'b00};
  // Reserved modes 2/3 fall through to the base address.
  assign w_vectored     = (i_mtvec.mode == VECTORED) && i_mcause.interrupt &&
                          (i_mcause.cause < 31'(VECTOR_CAUSES));

  always_comb begin
    o_target = w_base;
    if (i_kind == RET) begin
      o_target = w_mepc_aligned;
    end else if (w_vectored) begin
      o_target = w_base + w_offset;
    end
  end

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// Trap-entry / MRET-exit sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT, Moore outputs.
// Latency 3 to DRAIN_TIMEOUT+2 cycles request-to-redirect; requests ignored outside IDLE (upgrade only in DRAIN).
module priv_1_12_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int VECTOR_CAUSES = 16
) (
  input  logic                         CLK,
  input  logic                         nRST,
  priv_1_12_trap_sequencer_if.master   bus
);

  localparam int CW = $clog2(DRAIN_TIMEOUT);

  trap_seq_state_t r_state;
  trap_kind_t      r_kind;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;

  logic            w_cnt_last;
  logic [31:0]     w_target;

  assign w_cnt_last = (r_cnt == CW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_kind    <= TRAP;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.trap_req) begin
            r_state <= DRAIN;
            r_kind  <= TRAP;
          end else if (bus.mret) begin
            r_state <= DRAIN;
            r_kind  <= RET;
          end
        end
        DRAIN: begin
          // A trap arriving while an MRET drains takes over the sequence.
          if (bus.trap_req) begin
            r_kind <= TRAP;
          end
          if (bus.pipe_clear || w_cnt_last) begin
            r_state   <= COMMIT;
            r_cnt     <= '0;
            r_timeout <= !bus.pipe_clear;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        COMMIT:   r_state <= REDIRECT;
        REDIRECT: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  priv_1_12_trap_vector_calc #(
    .VECTOR_CAUSES (VECTOR_CAUSES)
  ) u_vector_calc (
    .i_mtvec  (bus.curr_mtvec),
    .i_mcause (bus.curr_mcause),
    .i_mepc   (bus.curr_mepc),
    .i_kind   (r_kind),
    .o_target (w_target)
  );

  assign bus.busy          = (r_state != IDLE);
  assign bus.pipe_stall    = (r_state != IDLE);
  assign bus.pipe_flush    = (r_state == COMMIT);
  assign bus.trap_commit   = (r_state == COMMIT) && (r_kind == TRAP);
  assign bus.mret_commit   = (r_state == COMMIT) && (r_kind == RET);
  assign bus.drain_timeout = (r_state == COMMIT) && r_timeout;
  assign bus.insert_pc     = (r_state == REDIRECT);
  // CSRs were updated on the COMMIT closing edge, so curr_* are already post-commit here.
  assign bus.priv_pc       = (r_state == REDIRECT) ? w_target : 32'h0;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Scoreboard bench for the trap sequencer: tasks push expected strobes (kind, cycle, pc),
// a negedge monitor pops and compares every strobe the DUT raises.
module tb_priv_1_12_trap_sequencer;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  priv_1_12_trap_sequencer_if bus();

  priv_1_12_trap_sequencer #(
    .DRAIN_TIMEOUT (16),
    .VECTOR_CAUSES (16)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // ev: 0 trap_commit, 1 mret_commit, 2 drain_timeout, 3 insert_pc
  typedef struct {
    int          ev;
    int          cyc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic [3:0] st;
    exp_t       x;
    st = {bus.insert_pc, bus.drain_timeout, bus.mret_commit, bus.trap_commit};
    for (int e = 0; e < 4; e++) begin
      if (st[e]) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got event %0d at cycle %0d, required no event", e, cyc);
        end else begin
          x = sb.pop_front();
          if (x.ev !== e || x.cyc !== cyc) begin
            n_fail++;
            $display("FAIL strobe_order: got event %0d at cycle %0d, required event %0d at cycle %0d",
                     e, cyc, x.ev, x.cyc);
          end else if (e == 3 && bus.priv_pc !== x.pc) begin
            n_fail++;
            $display("FAIL priv_pc: got %08h, required %08h (cycle %0d)", bus.priv_pc, x.pc, cyc);
          end
        end
      end
    end
    if (!bus.insert_pc) begin
      n_checks++;
      if (bus.priv_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL priv_pc_idle: got %08h, required 00000000 (cycle %0d)", bus.priv_pc, cyc);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic t, input logic m, input logic c, output int t0);
    @(posedge CLK);
    #1;
    bus.trap_req   = t;
    bus.mret       = m;
    bus.pipe_clear = c;
    t0 = cyc;
  endtask

  task automatic push(input int ev, input int c, input logic [31:0] pc);
    exp_t x;
    x.ev  = ev;
    x.cyc = c;
    x.pc  = pc;
    sb.push_back(x);
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) @(negedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sequence_timeout: got %0d strobes still pending, required 0", sb.size());
      sb.delete();
    end
    step();
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_seq: got %b, required 0", bus.busy);
    end
  endtask

  task automatic run_trap(input logic [31:0] mtvec, input logic [31:0] mcause, input logic [31:0] pc);
    int t0;
    bus.curr_mtvec  = mtvec;
    bus.curr_mcause = mcause;
    start(1'b1, 1'b0, 1'b1, t0);
    push(0, t0 + 2, 32'h0);
    push(3, t0 + 3, pc);
    step();
    bus.trap_req = 1'b0;
    wait_done(10);
  endtask

  task automatic test_reset();
    bus.trap_req    = 1'b0;
    bus.mret        = 1'b0;
    bus.pipe_clear  = 1'b1;
    bus.curr_mtvec  = 32'h0;
    bus.curr_mcause = 32'h0;
    bus.curr_mepc   = 32'h0;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({bus.pipe_stall, bus.pipe_flush, bus.trap_commit, bus.mret_commit,
         bus.insert_pc, bus.busy, bus.drain_timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {bus.pipe_stall, bus.pipe_flush, bus.trap_commit, bus.mret_commit,
                bus.insert_pc, bus.busy, bus.drain_timeout});
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_direct();
    run_trap(32'h8000_0100, 32'h0000_0002, 32'h8000_0100);
  endtask

  task automatic test_vectored();
    run_trap(32'h8000_0101, 32'h8000_0007, 32'h8000_011C);
    run_trap(32'h8000_0101, 32'h8000_0014, 32'h8000_0100);
    run_trap(32'h8000_0101, 32'h0000_0007, 32'h8000_0100);
    run_trap(32'h8000_0103, 32'h8000_0007, 32'h8000_0100);
    run_trap(32'h8000_0101, 32'h8000_000F, 32'h8000_013C);
  endtask

  task automatic test_mret();
    int t0;
    bus.curr_mepc = 32'h0000_2003;
    start(1'b0, 1'b1, 1'b1, t0);
    push(1, t0 + 2, 32'h0);
    push(3, t0 + 3, 32'h0000_2000);
    step();
    bus.mret = 1'b0;
    wait_done(10);
  endtask

  task automatic test_priority();
    int t0;
    bus.curr_mtvec  = 32'h8000_0100;
    bus.curr_mcause = 32'h0000_0002;
    bus.curr_mepc   = 32'h0000_2003;
    start(1'b1, 1'b1, 1'b1, t0);
    push(0, t0 + 2, 32'h0);
    push(3, t0 + 3, 32'h8000_0100);
    step();
    bus.trap_req = 1'b0;
    bus.mret     = 1'b0;
    wait_done(10);
    // MRET upgraded to trap while draining
    start(1'b0, 1'b1, 1'b0, t0);
    push(0, t0 + 3, 32'h0);
    push(3, t0 + 4, 32'h8000_0100);
    step();
    bus.mret     = 1'b0;
    bus.trap_req = 1'b1;
    step();
    bus.trap_req   = 1'b0;
    bus.pipe_clear = 1'b1;
    wait_done(10);
  endtask

  task automatic test_timeout();
    int t0;
    bus.curr_mtvec  = 32'h8000_0100;
    bus.curr_mcause = 32'h0000_0002;
    start(1'b1, 1'b0, 1'b0, t0);
    push(0, t0 + 17, 32'h0);
    push(2, t0 + 17, 32'h0);
    push(3, t0 + 18, 32'h8000_0100);
    step();
    bus.trap_req = 1'b0;
    wait_done(30);
    start(1'b1, 1'b0, 1'b0, t0);
    push(0, t0 + 6, 32'h0);
    push(3, t0 + 7, 32'h8000_0100);
    step();
    bus.trap_req = 1'b0;
    for (int i = 0; i < 10 && cyc < t0 + 5; i++) step();
    bus.pipe_clear = 1'b1;
    wait_done(10);
  endtask

  task automatic test_reset_mid_drain();
    int t0;
    start(1'b1, 1'b0, 1'b0, t0);
    step();
    bus.trap_req = 1'b0;
    step();
    step();
    nRST = 1'b0;
    #1;
    n_checks++;
    if ({bus.pipe_stall, bus.pipe_flush, bus.trap_commit, bus.mret_commit,
         bus.insert_pc, bus.busy, bus.drain_timeout, bus.priv_pc} !== 39'b0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got stall/flush/tc/mc/ins/busy/to=%b pc=%08h, required all 0",
               {bus.pipe_stall, bus.pipe_flush, bus.trap_commit, bus.mret_commit,
                bus.insert_pc, bus.busy, bus.drain_timeout}, bus.priv_pc);
    end
    step();
    step();
    nRST = 1'b1;
    bus.pipe_clear = 1'b1;
    repeat (20) step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_abort: got %b, required 0", bus.busy);
    end
    run_trap(32'hFFFF_FFFD, 32'h8000_0003, 32'h0000_0008);
  endtask

  task automatic test_back_to_back();
    int t0;
    bus.curr_mtvec  = 32'h8000_0100;
    bus.curr_mcause = 32'h0000_0002;
    start(1'b1, 1'b0, 1'b1, t0);
    push(0, t0 + 2, 32'h0);
    push(3, t0 + 3, 32'h8000_0100);
    push(0, t0 + 6, 32'h0);
    push(3, t0 + 7, 32'h8000_0100);
    for (int i = 0; i < 10 && cyc < t0 + 5; i++) step();
    bus.trap_req = 1'b0;
    wait_done(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_direct();
    test_vectored();
    test_mret();
    test_priority();
    test_timeout();
    test_reset_mid_drain();
    test_back_to_back();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
